sobel_frame_ctrl: RTL and testbench

//  Frame sequencer for the Sobel edge pipeline. On start it reads one IMG_WIDTH x IMG_HEIGHT
//  8-bit frame from a source RAM in raster order and streams it into sobel_top (pixel_in/data_valid).
//  It writes every edge_out/edge_valid result to a sink RAM at consecutive addresses.
//  It drains the pipeline, then signals done. Sits between the frame buffers and sobel_top.

---
 rtl/sobel_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl
//   Frame sequencer for the Sobel edge pipeline. When started, it reads one
//   IMG_WIDTH x IMG_HEIGHT frame of 8-bit pixels from a source RAM in raster
//   order and streams it into sobel_top. Every result that sobel_top returns
//   is written to a sink RAM at consecutive addresses. After the last pixel,
//   the sequencer waits for the pipeline to go quiet and then pulses done.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, abort, stall control levels (start sampled in IDLE only,
//                       abort from any state, stall only during FEED)
//   rd_en/rd_addr       source RAM read strobe and address
//   rd_data             source RAM data, valid one cycle after rd_en
//   pix_out/pix_valid   pixel stream to sobel_top
//   edge_in/edge_vld    result stream from sobel_top
//   wr_en/wr_addr/wr_data  sink RAM write port
//   busy                high while feeding or draining
//   done                one-cycle completion pulse
//   out_count           results written this frame (held until next start)
//   ovf                 sticky: a result arrived after the sink window was full
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH    = 256,
  parameter int IMG_HEIGHT   = 256,
  parameter int ADDR_W       = 16,
  parameter int DRAIN_CYCLES = 600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  input  logic [7:0]        edge_in,
  input  logic              edge_vld,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] out_count,
  output logic              ovf
);

  localparam int FRAME = IMG_WIDTH * IMG_HEIGHT;
  localparam int DW    = $clog2(DRAIN_CYCLES);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME - 1);
  // The write pointer carries one extra bit so that "all FRAME results
  // written" is representable even when 2**ADDR_W == FRAME.
  localparam logic [ADDR_W:0]   FRAME_CNT  = (ADDR_W + 1)'(FRAME);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]     wr_ptr_reg, wr_ptr_next;
  logic [DW-1:0]       drain_cnt_reg, drain_cnt_next;
  logic                ovf_reg, ovf_next;
  logic                pix_valid_reg;
  logic [7:0]          pix_hold_reg;

  logic active;      // result path enabled
  logic issue;       // a source read is issued this cycle
  logic frame_full;  // sink window already holds FRAME results
  logic accept;      // a result is written this cycle

  always_comb begin
    active     = (state_reg == S_FEED) || (state_reg == S_DRAIN);
    issue      = (state_reg == S_FEED) && !stall;
    frame_full = (wr_ptr_reg == FRAME_CNT);
    accept     = active && edge_vld && !frame_full;

    state_next     = state_reg;
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    drain_cnt_next = drain_cnt_reg;
    ovf_next       = ovf_reg;

    if (issue) begin
      rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
    end
    if (accept) begin
      wr_ptr_next = wr_ptr_reg + (ADDR_W + 1)'(1);
    end
    if (active && edge_vld && frame_full) begin
      ovf_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          state_next  = S_FEED;
          rd_ptr_next = '0;
          wr_ptr_next = '0;
          ovf_next    = 1'b0;
        end
      end
      S_FEED: begin
        drain_cnt_next = '0;
        if (abort) begin
          state_next = S_IDLE;
        end else if (issue && (rd_ptr_reg == LAST_ADDR)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Any result restarts the quiet-period count.
        drain_cnt_next = edge_vld ? '0 : drain_cnt_reg + DW'(1);
        if (abort) begin
          state_next = S_IDLE;
        end else if (!edge_vld && (drain_cnt_reg == DRAIN_LAST)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Addresses and write data are only meaningful alongside their strobes;
    // they are driven to zero otherwise so idle outputs stay quiet.
    rd_en     = issue;
    rd_addr   = issue ? rd_ptr_reg : '0;
    pix_valid = pix_valid_reg;
    // rd_data is already the RAM's registered output, so it lines up with
    // the delayed strobe; between pixels the last delivered value is held.
    pix_out   = pix_valid_reg ? rd_data : pix_hold_reg;
    wr_en     = accept;
    wr_addr   = accept ? wr_ptr_reg[ADDR_W-1:0] : '0;
    wr_data   = accept ? edge_in : '0;
    busy      = active;
    done      = (state_reg == S_DONE) && !abort;
    out_count = wr_ptr_reg[ADDR_W-1:0];
    ovf       = ovf_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      drain_cnt_reg <= '0;
      ovf_reg       <= 1'b0;
      pix_valid_reg <= 1'b0;
      pix_hold_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      drain_cnt_reg <= drain_cnt_next;
      ovf_reg       <= ovf_next;
      // A read issued in the abort cycle is discarded.
      pix_valid_reg <= issue && !abort;
      if (pix_valid_reg) begin
        pix_hold_reg <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl
//   Bench for sobel_frame_ctrl on a 4x4 frame. A ramp source RAM and a
//   fixed-latency stand-in for sobel_top (result = pixel ^ 8'h5A, five cycles
//   later) surround the DUT. A cycle model of the sequencer predicts every
//   output, and directed scenarios pin the model with hand-computed values.
module tb_sobel_frame_ctrl;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int AW    = 16;
  localparam int DC    = 20;
  localparam int FRAME = W * H;
  localparam int LAT   = 5;

  localparam int PH_IDLE  = 0;
  localparam int PH_FEED  = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic          force_vld = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic [7:0]    pix_out;
  logic          pix_valid;
  logic [7:0]    edge_in;
  logic          edge_vld;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] out_count;
  logic          ovf;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .ADDR_W      (AW),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .stall    (stall),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .pix_out  (pix_out),
    .pix_valid(pix_valid),
    .edge_in  (edge_in),
    .edge_vld (edge_vld),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .out_count(out_count),
    .ovf      (ovf)
  );

  // Source RAM: ramp contents, synchronous read.
  logic [7:0] src_ram [0:FRAME-1];
  always @(posedge clk) if (rd_en) rd_data <= src_ram[rd_addr[3:0]];

  // Stand-in for sobel_top: one result per pixel after LAT cycles.
  logic [LAT-1:0]   pipe_v = '0;
  logic [LAT*8-1:0] pipe_d = '0;
  always @(posedge clk) begin
    pipe_v <= {pipe_v[LAT-2:0], pix_valid};
    pipe_d <= {pipe_d[(LAT-1)*8-1:0], pix_out ^ 8'h5A};
  end
  assign edge_vld = force_vld | pipe_v[LAT-1];
  assign edge_in  = pipe_d[LAT*8-1 -: 8];

  // Reference model: which phase of the frame we are in, how many pixels
  // have been requested, how many results have been stored, and how long
  // the result stream has been quiet.
  int         m_phase   = PH_IDLE;
  int         m_next    = 0;
  int         m_wr      = 0;
  int         m_quiet   = 0;
  bit         m_ovf     = 1'b0;
  bit         m_if      = 1'b0;
  int         m_if_addr = 0;
  logic [7:0] m_hold    = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = PH_IDLE; m_next = 0; m_wr = 0; m_quiet = 0;
      m_ovf = 1'b0; m_if = 1'b0; m_if_addr = 0; m_hold = 8'h00;
    end else begin
      bit fetch;
      bit working;
      fetch   = (m_phase == PH_FEED) && !stall;
      working = (m_phase == PH_FEED) || (m_phase == PH_DRAIN);
      if (m_if) m_hold = src_ram[m_if_addr];
      m_if      = fetch && !abort;
      m_if_addr = m_next;
      if (working && edge_vld) begin
        if (m_wr < FRAME) m_wr++;
        else m_ovf = 1'b1;
      end
      case (m_phase)
        PH_IDLE: if (start && !abort) begin
          m_phase = PH_FEED; m_next = 0; m_wr = 0; m_ovf = 1'b0;
        end
        PH_FEED: if (abort) m_phase = PH_IDLE;
          else if (fetch) begin
            m_next++;
            if (m_next == FRAME) begin m_phase = PH_DRAIN; m_quiet = 0; end
          end
        PH_DRAIN: if (abort) m_phase = PH_IDLE;
          else begin
            m_quiet = edge_vld ? 0 : m_quiet + 1;
            if (m_quiet == DC) m_phase = PH_DONE;
          end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ev_cnt = 0;
  int rd_log[$];
  int rd_cyc[$];
  int pix_log[$];
  int pv_cyc[$];
  int wa_log[$];
  int wd_log[$];
  int rb, pb, wb, db, eb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic compare_cycle();
    logic       e_busy, e_rd, e_wr, e_done;
    logic [7:0] e_pix;
    e_busy = (m_phase == PH_FEED) || (m_phase == PH_DRAIN);
    e_rd   = (m_phase == PH_FEED) && !stall;
    e_wr   = e_busy && edge_vld && (m_wr < FRAME);
    e_done = (m_phase == PH_DONE) && !abort;
    e_pix  = m_if ? src_ram[m_if_addr] : m_hold;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("rd_addr", 32'(rd_addr), e_rd ? m_next : 0);
    chk("pix_valid", 32'(pix_valid), 32'(m_if));
    chk("pix_out", 32'(pix_out), 32'(e_pix));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("wr_addr", 32'(wr_addr), e_wr ? m_wr : 0);
    chk("wr_data", 32'(wr_data), e_wr ? 32'(edge_in) : 0);
    chk("done", 32'(done), 32'(e_done));
    chk("out_count", 32'(out_count), m_wr);
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (rd_en) begin rd_log.push_back(int'(rd_addr)); rd_cyc.push_back(cyc); end
    if (pix_valid) begin pix_log.push_back(int'(pix_out)); pv_cyc.push_back(cyc); end
    if (wr_en) begin wa_log.push_back(int'(wr_addr)); wd_log.push_back(int'(wr_data)); end
    if (done) done_cnt++;
    if (busy && edge_vld) ev_cnt++;
    cyc++;
  endtask

  // One clock cycle: compare on the falling edge, return just after the
  // next rising edge so the caller can drive the following cycle's inputs.
  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snap();
    rb = rd_log.size(); pb = pix_log.size(); wb = wa_log.size();
    db = done_cnt; eb = ev_cnt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin tick(); n++; end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL %s actual=no done in %0d cycles required=done pulse", nm, budget);
    end
  endtask

  task automatic check_clean_frame(input string nm);
    chk({nm, "_reads"}, rd_log.size() - rb, FRAME);
    for (int i = 0; i < FRAME; i++)
      if (rb + i < rd_log.size()) chk({nm, "_rd_addr"}, rd_log[rb + i], i);
    chk({nm, "_pixels"}, pix_log.size() - pb, FRAME);
    for (int i = 0; i < FRAME; i++)
      if (pb + i < pix_log.size()) chk({nm, "_pix"}, pix_log[pb + i], i);
    chk({nm, "_writes"}, wa_log.size() - wb, FRAME);
    for (int i = 0; i < FRAME; i++)
      if (wb + i < wa_log.size()) begin
        chk({nm, "_wr_addr"}, wa_log[wb + i], i);
        chk({nm, "_wr_data"}, wd_log[wb + i], i ^ 'h5A);
      end
    chk({nm, "_dones"}, done_cnt - db, 1);
    chk({nm, "_out_count"}, 32'(out_count), FRAME);
    chk({nm, "_out_count_vs_edges"}, 32'(out_count), ev_cnt - eb);
    $display("%s frame: reads=%0d pixels=%0d writes=%0d out_count=%0d dones=%0d",
             nm, rd_log.size() - rb, pix_log.size() - pb, wa_log.size() - wb,
             out_count, done_cnt - db);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=summary reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < FRAME; i++) src_ram[i] = 8'(i);

    // Reset state
    ticks(3);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_out_count", 32'(out_count), 0);
    rst = 1'b1;
    ticks(2);

    // T1: plain frame
    snap();
    pulse_start();
    wait_done("t1_done", 200);
    check_clean_frame("t1");
    chk("t1_read_span", rd_cyc[rb + FRAME - 1] - rd_cyc[rb], FRAME - 1);
    chk("t1_pix_lag", pv_cyc[pb] - rd_cyc[rb], 1);

    // T2: stall on FEED cycles 3..5
    ticks(2);
    snap();
    pulse_start();
    ticks(2);
    stall = 1'b1;
    ticks(3);
    stall = 1'b0;
    wait_done("t2_done", 200);
    check_clean_frame("t2");
    chk("t2_rd_gap", rd_cyc[rb + 2] - rd_cyc[rb + 1], 4);
    chk("t2_pv_gap", pv_cyc[pb + 2] - pv_cyc[pb + 1], 4);
    chk("t2_pv_span", pv_cyc[pb + FRAME - 1] - pv_cyc[pb] + 1 - FRAME, 3);

    // T3: abort on the 8th FEED cycle, then a clean restart
    ticks(2);
    snap();
    pulse_start();
    ticks(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_busy_after_abort", 32'(busy), 0);
    chk("t3_rd_en_after_abort", 32'(rd_en), 0);
    chk("t3_pix_valid_after_abort", 32'(pix_valid), 0);
    chk("t3_reads", rd_log.size() - rb, 8);
    chk("t3_pixels", pix_log.size() - pb, 7);
    chk("t3_out_count", 32'(out_count), 2);
    ticks(10);
    chk("t3_out_count_hold", 32'(out_count), 2);
    chk("t3_writes", wa_log.size() - wb, 2);
    chk("t3_no_done", done_cnt - db, 0);
    $display("t3 abort: reads=%0d pixels=%0d out_count=%0d", rd_log.size() - rb,
             pix_log.size() - pb, out_count);
    snap();
    pulse_start();
    wait_done("t3_restart_done", 200);
    check_clean_frame("t3r");

    // T4: start held through a frame
    ticks(2);
    snap();
    start = 1'b1;
    tick();
    wait_done("t4_first_done", 200);
    chk("t4_idle_between", 32'(busy), 0);
    chk("t4_one_done", done_cnt - db, 1);
    chk("t4_one_frame", rd_log.size() - rb, FRAME);
    tick();
    chk("t4_second_busy", 32'(busy), 1);
    chk("t4_second_rd_en", 32'(rd_en), 1);
    chk("t4_second_rd_addr", 32'(rd_addr), 0);
    start = 1'b0;
    wait_done("t4_second_done", 200);
    chk("t4_two_dones", done_cnt - db, 2);
    chk("t4_two_frames", rd_log.size() - rb, 2 * FRAME);
    $display("t4 held start: frames=%0d dones=%0d", (rd_log.size() - rb) / FRAME, done_cnt - db);

    // T5: results forced for 20 cycles -> window fills, ovf sets
    ticks(2);
    snap();
    pulse_start();
    force_vld = 1'b1;
    ticks(20);
    force_vld = 1'b0;
    chk("t5_ovf_set", 32'(ovf), 1);
    wait_done("t5_done", 200);
    chk("t5_writes", wa_log.size() - wb, FRAME);
    for (int i = 0; i < FRAME; i++)
      if (wb + i < wa_log.size()) chk("t5_wr_addr", wa_log[wb + i], i);
    chk("t5_out_count", 32'(out_count), FRAME);
    chk("t5_ovf_sticky", 32'(ovf), 1);
    $display("t5 overflow: writes=%0d out_count=%0d ovf=%0d", wa_log.size() - wb, out_count, ovf);
    ticks(2);
    pulse_start();
    chk("t5_ovf_cleared", 32'(ovf), 0);
    chk("t5_count_cleared", 32'(out_count), 0);
    wait_done("t5_next_done", 200);

    // T6: asynchronous reset during DRAIN
    ticks(2);
    pulse_start();
    ticks(19);
    chk("t6_in_drain", 32'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rd_en", 32'(rd_en), 0);
    chk("t6_pix_valid", 32'(pix_valid), 0);
    chk("t6_pix_out", 32'(pix_out), 0);
    chk("t6_wr_en", 32'(wr_en), 0);
    chk("t6_wr_data", 32'(wr_data), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_out_count", 32'(out_count), 0);
    chk("t6_ovf", 32'(ovf), 0);
    ticks(2);
    rst = 1'b1;
    ticks(10);
    snap();
    pulse_start();
    wait_done("t6_done", 200);
    check_clean_frame("t6");

    ticks(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
